// File: rtl/rpc_ctrl_pkg.sv
// Shared types for the RPC controller front end: arbiter FSM states and the packed command
// record carried from each upstream channel to the controller command port.
package rpc_ctrl_pkg;

  localparam int RPC_ADDR_W = 20;
  localparam int RPC_LEN_W  = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2
  } rpc_arb_state_e;

  typedef struct packed {
    logic                  write;
    logic [RPC_ADDR_W-1:0] addr;
    logic [RPC_LEN_W-1:0]  len;
  } rpc_cmd_t;

endpackage

// File: rtl/rpc_rr_starve_sel.sv
// Winner selection for the command arbiter: round-robin from a rotating pointer, overridden
// by any valid port that has lost MaxWait rounds. Pointer and wait counters advance on commit.
module rpc_rr_starve_sel #(
  parameter int NumPorts = 2,
  parameter int MaxWait  = 7,
  parameter int IdxW     = 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NumPorts-1:0] valid_i,
  input  logic                commit_i,
  output logic [IdxW-1:0]     pick_o,
  output logic                any_o
);

  localparam int WaitW = $clog2(MaxWait + 1);

  logic [IdxW-1:0]     rr_reg;
  logic [NumPorts-1:0] starve;
  logic [NumPorts-1:0] upper;

  for (genvar gi = 0; gi < NumPorts; gi++) begin : g_port
    logic [WaitW-1:0] wait_reg;

    assign starve[gi] = valid_i[gi] && (wait_reg == WaitW'(MaxWait));
    // Valid ports at or above the pointer; the wrap case falls back to plain lowest-valid.
    assign upper[gi]  = valid_i[gi] && (gi >= int'(rr_reg));

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        wait_reg <= '0;
      end else if (commit_i) begin
        if (pick_o == IdxW'(gi)) begin
          wait_reg <= '0;
        end else if (valid_i[gi] && (wait_reg != WaitW'(MaxWait))) begin
          wait_reg <= wait_reg + 1'b1;
        end
      end
    end
  end

  always_comb begin
    pick_o = '0;
    if (|starve) begin
      for (int i = NumPorts - 1; i >= 0; i--) begin
        if (starve[i]) pick_o = IdxW'(i);
      end
    end else if (|upper) begin
      for (int i = NumPorts - 1; i >= 0; i--) begin
        if (upper[i]) pick_o = IdxW'(i);
      end
    end else begin
      for (int i = NumPorts - 1; i >= 0; i--) begin
        if (valid_i[i]) pick_o = IdxW'(i);
      end
    end
  end

  assign any_o = |valid_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_reg <= '0;
    end else if (commit_i) begin
      rr_reg <= (int'(pick_o) == NumPorts - 1) ? '0 : pick_o + IdxW'(1);
    end
  end

endmodule

// File: rtl/rpc_cmd_arbiter.sv
// Arbitrates NumPorts upstream RPC command channels onto the single controller command port,
// holding the grant through the data phase so sel_o can steer the shared data path.
module rpc_cmd_arbiter
  import rpc_ctrl_pkg::*;
#(
  parameter int NumPorts      = 2,
  parameter int DramAddrWidth = 20,
  parameter int DramLenWidth  = 6,
  parameter int MaxWait       = 7,
  localparam int IdxW         = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [NumPorts-1:0]                    req_valid_i,
  output logic [NumPorts-1:0]                    req_ready_o,
  input  logic [NumPorts-1:0]                    req_write_i,
  input  logic [NumPorts-1:0][DramAddrWidth-1:0] req_addr_i,
  input  logic [NumPorts-1:0][DramLenWidth-1:0]  req_len_i,
  output logic                                   cmd_valid_o,
  input  logic                                   cmd_ready_i,
  output logic                                   cmd_write_o,
  output logic [DramAddrWidth-1:0]               cmd_addr_o,
  output logic [DramLenWidth-1:0]                cmd_len_o,
  input  logic                                   done_i,
  output logic [IdxW-1:0]                        sel_o,
  output logic                                   sel_valid_o
);

  rpc_arb_state_e  state_reg, state_next;
  logic [IdxW-1:0] grant_reg, grant_next;
  logic [IdxW-1:0] pick;
  logic            any_valid;
  logic            commit;
  rpc_cmd_t        req_cmd [NumPorts];
  rpc_cmd_t        granted;

  // Command records use the package field widths; ports wider than those are truncated.
  for (genvar gi = 0; gi < NumPorts; gi++) begin : g_pack
    assign req_cmd[gi] = '{write: req_write_i[gi],
                           addr:  RPC_ADDR_W'(req_addr_i[gi]),
                           len:   RPC_LEN_W'(req_len_i[gi])};
  end

  assign commit  = (state_reg == IDLE) && any_valid;
  assign granted = req_cmd[grant_reg];

  rpc_rr_starve_sel #(
    .NumPorts (NumPorts),
    .MaxWait  (MaxWait),
    .IdxW     (IdxW)
  ) u_sel (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .valid_i  (req_valid_i),
    .commit_i (commit),
    .pick_o   (pick),
    .any_o    (any_valid)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
      grant_reg <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    case (state_reg)
      IDLE: begin
        if (any_valid) begin
          state_next = ISSUE;
          grant_next = pick;
        end
      end
      ISSUE:   if (cmd_ready_i) state_next = BUSY;
      BUSY:    if (done_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cmd_valid_o = 1'b0;
    cmd_write_o = 1'b0;
    cmd_addr_o  = '0;
    cmd_len_o   = '0;
    req_ready_o = '0;
    sel_valid_o = (state_reg == ISSUE) || (state_reg == BUSY);
    if (state_reg == ISSUE) begin
      cmd_valid_o            = 1'b1;
      cmd_write_o            = granted.write;
      cmd_addr_o             = DramAddrWidth'(granted.addr);
      cmd_len_o              = DramLenWidth'(granted.len);
      req_ready_o[grant_reg] = cmd_ready_i;
    end
  end

  assign sel_o = grant_reg;

  a_cmd_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (cmd_valid_o && !cmd_ready_i) |=> $stable({cmd_write_o, cmd_addr_o, cmd_len_o}));
  a_ready_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(req_ready_o));
  a_no_valid_drop: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_reg == ISSUE) |-> req_valid_i[grant_reg]);

endmodule

// File: tb/tb_rpc_cmd_arbiter.sv
// Drives two 4-port arbiters in lockstep (MaxWait 7 and 2) from shared stimulus and checks
// grants, command fields and handshakes against a rule-level reference model.
module tb_rpc_cmd_arbiter;

  localparam int NP = 4;
  localparam int AW = 20;
  localparam int LW = 6;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NP-1:0]          req_valid = '0;
  logic [NP-1:0]          req_write = '0;
  logic [NP-1:0][AW-1:0]  req_addr = '0;
  logic [NP-1:0][LW-1:0]  req_len = '0;
  logic                   cmd_ready = 1'b0;
  logic                   done = 1'b0;

  logic [NP-1:0] a_req_ready, b_req_ready;
  logic          a_cmd_valid, b_cmd_valid, a_cmd_write, b_cmd_write;
  logic [AW-1:0] a_cmd_addr, b_cmd_addr;
  logic [LW-1:0] a_cmd_len, b_cmd_len;
  logic [1:0]    a_sel, b_sel;
  logic          a_sel_valid, b_sel_valid;

  int checks = 0;
  int errors = 0;
  int txn_no = 0;

  int rr_m [2];
  int wait_m [2][NP];
  int maxw_m [2] = '{7, 2};

  always #5 clk = ~clk;

  rpc_cmd_arbiter #(.NumPorts(NP), .DramAddrWidth(AW), .DramLenWidth(LW), .MaxWait(7)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(a_req_ready),
    .req_write_i(req_write), .req_addr_i(req_addr), .req_len_i(req_len),
    .cmd_valid_o(a_cmd_valid), .cmd_ready_i(cmd_ready), .cmd_write_o(a_cmd_write),
    .cmd_addr_o(a_cmd_addr), .cmd_len_o(a_cmd_len), .done_i(done),
    .sel_o(a_sel), .sel_valid_o(a_sel_valid));

  rpc_cmd_arbiter #(.NumPorts(NP), .DramAddrWidth(AW), .DramLenWidth(LW), .MaxWait(2)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(b_req_ready),
    .req_write_i(req_write), .req_addr_i(req_addr), .req_len_i(req_len),
    .cmd_valid_o(b_cmd_valid), .cmd_ready_i(cmd_ready), .cmd_write_o(b_cmd_write),
    .cmd_addr_o(b_cmd_addr), .cmd_len_o(b_cmd_len), .done_i(done),
    .sel_o(b_sel), .sel_valid_o(b_sel_valid));

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      rr_m[m] = 0;
      for (int p = 0; p < NP; p++) wait_m[m][p] = 0;
    end
  endtask

  // Apply the arbitration rules to one IDLE cycle with valid mask vm; g = -1 if nobody asks.
  task automatic model_grant(input int m, input logic [NP-1:0] vm, output int g);
    g = -1;
    for (int p = 0; p < NP; p++)
      if (g < 0 && vm[p] && wait_m[m][p] == maxw_m[m]) g = p;
    for (int off = 0; off < NP; off++)
      if (g < 0 && vm[(rr_m[m] + off) % NP]) g = (rr_m[m] + off) % NP;
    if (g >= 0) begin
      for (int p = 0; p < NP; p++) begin
        if (p == g) wait_m[m][p] = 0;
        else if (vm[p] && wait_m[m][p] < maxw_m[m]) wait_m[m][p]++;
      end
      rr_m[m] = (g + 1) % NP;
    end
  endtask

  task automatic new_fields(input int p);
    req_write[p] = 1'($urandom_range(0, 1));
    req_addr[p]  = AW'($urandom);
    req_len[p]   = LW'($urandom);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0;
    cmd_ready = 1'b0;
    done = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // From an IDLE negedge: present vm, let the arbiter grant, return at the ISSUE negedge.
  task automatic go_issue(input logic [NP-1:0] vm, output int ga, output int gb);
    req_valid = vm;
    model_grant(0, vm, ga);
    model_grant(1, vm, gb);
    @(posedge clk);
    @(negedge clk);
    txn_no++;
    $display("txn %0d: valid=%b grant_a=%0d (sel %0d) grant_b=%0d (sel %0d) addr=%h",
             txn_no, vm, ga, a_sel, gb, b_sel, a_cmd_addr);
  endtask

  task automatic accept(input int ga);
    cmd_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_ready = 1'b0;
    new_fields(ga);
  endtask

  task automatic finish_cmd(input int dly);
    repeat (dly) @(negedge clk);
    done = 1'b1;
    @(posedge clk);
    @(negedge clk);
    done = 1'b0;
  endtask

  task automatic test_reset();
    int ga, gb;
    rst_n = 1'b0;
    req_valid = '1;
    cmd_ready = 1'b1;
    done = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({a_cmd_valid, a_req_ready, a_sel_valid, a_sel, a_cmd_write, a_cmd_addr, a_cmd_len} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_a: got valid=%b ready=%b selv=%b sel=%0d addr=%h, required all 0",
               a_cmd_valid, a_req_ready, a_sel_valid, a_sel, a_cmd_addr);
    end
    checks++;
    if ({b_cmd_valid, b_req_ready, b_sel_valid, b_sel, b_cmd_write, b_cmd_addr, b_cmd_len} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_b: got valid=%b ready=%b selv=%b sel=%0d, required all 0",
               b_cmd_valid, b_req_ready, b_sel_valid, b_sel);
    end
    cmd_ready = 1'b0;
    done = 1'b0;
    rst_n = 1'b1;
    model_reset();
    #1;
    checks++;
    if (a_cmd_valid !== 1'b0 || a_sel_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: got cmd_valid=%b sel_valid=%b, required 0 0",
               a_cmd_valid, a_sel_valid);
    end
    go_issue('1, ga, gb);
    checks++;
    if (a_cmd_valid !== 1'b1 || a_sel !== 2'(ga) || b_sel !== 2'(gb)) begin
      errors++;
      $display("FAIL reset_first_grant: got valid=%b sel_a=%0d sel_b=%0d, required 1 %0d %0d",
               a_cmd_valid, a_sel, b_sel, ga, gb);
    end
    accept(ga);
    finish_cmd(0);
  endtask

  task automatic test_round_robin();
    int ga, gb;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      go_issue('1, ga, gb);
      checks++;
      if (a_sel !== 2'(ga) || a_sel_valid !== 1'b1 ||
          {a_cmd_write, a_cmd_addr, a_cmd_len} !== {req_write[ga], req_addr[ga], req_len[ga]}) begin
        errors++;
        $display("FAIL rr_grant_a: got sel=%0d addr=%h len=%0d, required sel=%0d addr=%h len=%0d",
                 a_sel, a_cmd_addr, a_cmd_len, ga, req_addr[ga], req_len[ga]);
      end
      checks++;
      if (b_sel !== 2'(gb)) begin
        errors++;
        $display("FAIL rr_grant_b: got sel=%0d, required %0d", b_sel, gb);
      end
      accept(ga);
      finish_cmd(0);
    end
  endtask

  task automatic test_wrap();
    int ga, gb;
    do_reset();
    go_issue(4'b0010, ga, gb);
    accept(ga);
    finish_cmd(0);
    for (int k = 0; k < 2; k++) begin
      go_issue(4'b1010, ga, gb);
      checks++;
      if (a_sel !== 2'(ga) || b_sel !== 2'(gb) || a_cmd_addr !== req_addr[ga]) begin
        errors++;
        $display("FAIL wrap_grant: got sel_a=%0d sel_b=%0d, required %0d %0d", a_sel, b_sel, ga, gb);
      end
      accept(ga);
      finish_cmd(1);
    end
  endtask

  task automatic test_backpressure();
    int ga, gb;
    logic [AW+LW:0] snap;
    logic [NP-1:0]  vm;
    vm = NP'($urandom_range(1, 15));
    go_issue(vm, ga, gb);
    snap = {a_cmd_write, a_cmd_addr, a_cmd_len};
    checks++;
    if (snap !== {req_write[ga], req_addr[ga], req_len[ga]} || a_sel !== 2'(ga)) begin
      errors++;
      $display("FAIL bp_fields: got sel=%0d cmd=%h, required sel=%0d cmd=%h",
               a_sel, snap, ga, {req_write[ga], req_addr[ga], req_len[ga]});
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (a_cmd_valid !== 1'b1 || {a_cmd_write, a_cmd_addr, a_cmd_len} !== snap ||
          a_req_ready !== '0 || b_req_ready !== '0) begin
        errors++;
        $display("FAIL bp_stall: cycle %0d got valid=%b cmd=%h ready_a=%b ready_b=%b, required 1 %h 0 0",
                 c, a_cmd_valid, {a_cmd_write, a_cmd_addr, a_cmd_len}, a_req_ready, b_req_ready, snap);
      end
    end
    cmd_ready = 1'b1;
    #1;
    checks++;
    if (a_req_ready !== NP'(1 << ga) || b_req_ready !== NP'(1 << gb)) begin
      errors++;
      $display("FAIL bp_accept: got ready_a=%b ready_b=%b, required %b %b",
               a_req_ready, b_req_ready, NP'(1 << ga), NP'(1 << gb));
    end
    @(posedge clk);
    @(negedge clk);
    cmd_ready = 1'b0;
    new_fields(ga);
    checks++;
    if (a_cmd_valid !== 1'b0 || a_sel_valid !== 1'b1 || a_req_ready !== '0) begin
      errors++;
      $display("FAIL bp_busy: got valid=%b selv=%b ready=%b, required 0 1 0",
               a_cmd_valid, a_sel_valid, a_req_ready);
    end
    finish_cmd($urandom_range(0, 3));
  endtask

  task automatic test_starvation();
    int ga, gb, lost;
    int pre_port [3] = '{0, 1, 3};
    do_reset();
    for (int ep = 0; ep < 4; ep++) begin
      go_issue(NP'(1 << pre_port[$urandom_range(0, 2)]), ga, gb);
      accept(ga);
      finish_cmd(0);
      lost = 0;
      for (int r = 0; r < 6; r++) begin
        go_issue(4'b0111, ga, gb);
        checks++;
        if (b_sel !== 2'(gb) || a_sel !== 2'(ga)) begin
          errors++;
          $display("FAIL starve_grant: got sel_a=%0d sel_b=%0d, required %0d %0d", a_sel, b_sel, ga, gb);
        end
        accept(ga);
        finish_cmd(0);
        if (b_sel == 2'd2) break;
        lost++;
      end
      checks++;
      if (lost > 2) begin
        errors++;
        $display("FAIL starve_bound: port 2 lost %0d rounds, required at most 2", lost);
      end
    end
  endtask

  task automatic test_reset_busy();
    int ga, gb;
    do_reset();
    go_issue(4'b0101, ga, gb);
    accept(ga);
    checks++;
    if (a_sel_valid !== 1'b1 || a_cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL busy_state: got selv=%b valid=%b, required 1 0", a_sel_valid, a_cmd_valid);
    end
    rst_n = 1'b0;
    req_valid = '0;
    #1;
    checks++;
    if ({a_cmd_valid, a_req_ready, a_sel_valid, a_sel} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got valid=%b ready=%b selv=%b sel=%0d, required all 0",
               a_cmd_valid, a_req_ready, a_sel_valid, a_sel);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    done = 1'b1;
    @(posedge clk);
    @(negedge clk);
    done = 1'b0;
    checks++;
    if (a_cmd_valid !== 1'b0 || a_sel_valid !== 1'b0 || a_req_ready !== '0 || b_req_ready !== '0) begin
      errors++;
      $display("FAIL done_in_idle: got valid=%b selv=%b ready=%b, required 0 0 0",
               a_cmd_valid, a_sel_valid, a_req_ready);
    end
    go_issue(4'b0110, ga, gb);
    done = 1'b1;
    @(posedge clk);
    @(negedge clk);
    done = 1'b0;
    checks++;
    if (a_cmd_valid !== 1'b1 || a_req_ready !== '0 || a_sel !== 2'(ga) || b_sel !== 2'(gb)) begin
      errors++;
      $display("FAIL done_in_issue: got valid=%b ready=%b sel=%0d, required 1 0 %0d",
               a_cmd_valid, a_req_ready, a_sel, ga);
    end
    accept(ga);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (a_sel_valid !== 1'b1 || a_cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL busy_hold: got selv=%b valid=%b, required 1 0", a_sel_valid, a_cmd_valid);
    end
    finish_cmd(0);
  endtask

  task automatic test_random();
    int ga, gb;
    logic [NP-1:0] vm;
    for (int t = 0; t < 40; t++) begin
      vm = NP'($urandom_range(0, 15));
      if (vm == '0) begin
        req_valid = '0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (a_cmd_valid !== 1'b0 || a_sel_valid !== 1'b0 || b_sel_valid !== 1'b0) begin
          errors++;
          $display("FAIL rand_idle: got valid=%b selv_a=%b selv_b=%b, required 0 0 0",
                   a_cmd_valid, a_sel_valid, b_sel_valid);
        end
        continue;
      end
      go_issue(vm, ga, gb);
      checks++;
      if (a_sel !== 2'(ga) || b_sel !== 2'(gb) ||
          {a_cmd_write, a_cmd_addr, a_cmd_len} !== {req_write[ga], req_addr[ga], req_len[ga]}) begin
        errors++;
        $display("FAIL rand_grant: got sel_a=%0d sel_b=%0d addr=%h, required %0d %0d %h",
                 a_sel, b_sel, a_cmd_addr, ga, gb, req_addr[ga]);
      end
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        @(negedge clk);
      end
      cmd_ready = 1'b1;
      #1;
      checks++;
      if (a_req_ready !== NP'(1 << ga) || b_req_ready !== NP'(1 << gb)) begin
        errors++;
        $display("FAIL rand_accept: got ready_a=%b ready_b=%b, required %b %b",
                 a_req_ready, b_req_ready, NP'(1 << ga), NP'(1 << gb));
      end
      @(posedge clk);
      @(negedge clk);
      cmd_ready = 1'b0;
      new_fields(ga);
      finish_cmd($urandom_range(0, 3));
    end
  endtask

  initial begin
    for (int p = 0; p < NP; p++) new_fields(p);
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_wrap();
    test_backpressure();
    test_starvation();
    test_reset_busy();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
